// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner: row-at-a-time drive, frame-level debounce, key-event FIFO with sticky overflow.
// Optional macro KEYPAD_RELEASE_EVT_EN adds key-release events ({1'b1,code}) to the FIFO.
`default_nettype none

module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 30000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] cols_in,
    output logic [3:0] rows_out,
    output logic [3:0] key_held,
    output logic [4:0] evt_data,
    output logic       evt_valid,
    input  logic       evt_pop,
    output logic [4:0] evt_count,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic [1:0] scan_state
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]    DB_CNT     = 4'(DEBOUNCE_FRAMES);
    localparam logic [4:0]    FULL_CNT   = 5'(FIFO_DEPTH);
    localparam logic [3:0]    CODE_NONE  = 4'hF;
    localparam logic [3:0]    CODE_MULTI = 4'hE;

    typedef enum logic [1:0] {S_R0, S_R1, S_R2, S_R3} scan_t;

    scan_t          state;
    logic [CW-1:0]  dwell;
    logic [2:0]     c_s1, c_s2;
    logic [1:0]     acc_cnt;
    logic [3:0]     acc_code;
    logic [3:0]     cand;
    logic [3:0]     stable_cnt;

    logic [2:0]     col_low;
    logic [1:0]     n_low;
    logic [1:0]     row_col;
    logic [1:0]     row_idx;
    logic [2:0]     tot;
    logic [3:0]     row_code;
    logic [3:0]     frame_code;
    logic [3:0]     result;
    logic           sample;
    logic           frame_end;
    logic [3:0]     nxt_cnt;
    logic           upd;
    logic           push;
    logic [4:0]     push_data;

    assign scan_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_s1 <= 3'b111;
            c_s2 <= 3'b111;
        end else begin
            c_s1 <= cols_in;
            c_s2 <= c_s1;
        end
    end

    // Per-row sample folded into a running frame summary: low-bit count (saturating at 2) and last single-key code.
    always_comb begin
        row_idx    = state;
        col_low    = ~c_s2;
        n_low      = {1'b0, col_low[0]} + {1'b0, col_low[1]} + {1'b0, col_low[2]};
        row_col    = col_low[0] ? 2'd0 : (col_low[1] ? 2'd1 : 2'd2);
        tot        = {1'b0, acc_cnt} + {1'b0, n_low};
        row_code   = ({2'b00, row_idx} * 4'd3) + {2'b00, row_col};
        frame_code = (n_low == 2'd1) ? row_code : acc_code;
        if (tot == 3'd0)
            result = CODE_NONE;
        else if (tot == 3'd1)
            result = frame_code;
        else
            result = CODE_MULTI;
        sample    = (dwell == DWELL_LAST);
        frame_end = sample && (state == S_R3);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_R0;
            dwell    <= '0;
            rows_out <= 4'b1110;
            acc_cnt  <= 2'd0;
            acc_code <= 4'd0;
        end else if (sample) begin
            dwell <= '0;
            if (frame_end) begin
                acc_cnt  <= 2'd0;
                acc_code <= 4'd0;
            end else begin
                acc_cnt  <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
                acc_code <= frame_code;
            end
            case (state)
                S_R0: begin state <= S_R1; rows_out <= 4'b1101; end
                S_R1: begin state <= S_R2; rows_out <= 4'b1011; end
                S_R2: begin state <= S_R3; rows_out <= 4'b0111; end
                S_R3: begin state <= S_R0; rows_out <= 4'b1110; end
            endcase
        end else begin
            dwell <= dwell + CW'(1);
        end
    end

    always_comb begin
        if (result == cand)
            nxt_cnt = (stable_cnt == DB_CNT) ? stable_cnt : stable_cnt + 4'd1;
        else
            nxt_cnt = 4'd1;
        upd = frame_end && (nxt_cnt == DB_CNT) && (result != CODE_MULTI) && (result != key_held);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cand       <= CODE_NONE;
            stable_cnt <= 4'd0;
            key_held   <= CODE_NONE;
        end else if (frame_end) begin
            cand       <= result;
            stable_cnt <= nxt_cnt;
            if (upd)
                key_held <= result;
        end
    end

`ifdef KEYPAD_RELEASE_EVT_EN
    logic       pend_valid;
    logic       pend_set;
    logic [3:0] pend_code;

    // A key->key change releases the old key now and presses the new one on the next cycle.
    always_comb begin
        push      = 1'b0;
        push_data = 5'd0;
        pend_set  = 1'b0;
        if (pend_valid) begin
            push      = 1'b1;
            push_data = {1'b0, pend_code};
        end else if (upd) begin
            push = 1'b1;
            if (key_held != CODE_NONE) begin
                push_data = {1'b1, key_held};
                pend_set  = (result != CODE_NONE);
            end else begin
                push_data = {1'b0, result};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_code  <= 4'd0;
        end else begin
            pend_valid <= pend_set;
            if (pend_set)
                pend_code <= result;
        end
    end
`else
    always_comb begin
        push      = upd && (result != CODE_NONE);
        push_data = {1'b0, result};
    end
`endif

    logic [4:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          pop_ok, full, wr_ok, drop;

    always_comb begin
        pop_ok = evt_pop && (evt_count != 5'd0);
        full   = (evt_count == FULL_CNT);
        wr_ok  = push && (!full || pop_ok);
        drop   = push && full && !pop_ok;
    end

    assign evt_valid = (evt_count != 5'd0);
    assign evt_data  = evt_valid ? mem[rd_ptr] : 5'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= 5'd0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= 5'd0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + PW'(1);
            if (wr_ok && !pop_ok)
                evt_count <= evt_count + 5'd1;
            else if (pop_ok && !wr_ok)
                evt_count <= evt_count - 5'd1;
        end
    end

    // A drop on the same edge as a clear wins, so the lost event is never hidden.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

endmodule

`default_nettype wire
